// File: rtl/core_ctrl_pkg.sv
// Shared types for the core pipeline controller.
package core_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } ctrl_state_e;

    // Hold/bubble controls for the four pipeline registers behind IF.
    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_exe;
        logic stall_mem;
        logic flush_id;
        logic flush_exe;
        logic flush_mem;
        logic flush_wb;
    } pipe_ctrl_t;

endpackage

// File: rtl/perf_counter.sv
// Wrapping event counter with synchronous clear.
module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count one event per cycle, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush arbitration, MDU wait sequencing and performance counters
// for the 5-stage core.
module pipeline_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_hazard,
    input  logic             branch_hazard,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             mdu_op_exe,
    input  logic             mdu_done,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_exe,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_exe,
    output logic             flush_mem,
    output logic             flush_wb,
    output logic             mdu_start,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_branch_flushes,
    output logic [CNT_W-1:0] perf_load_bubbles
);

    ctrl_state_e state_q, state_d;
    logic        launched_q, launched_d;
    pipe_ctrl_t  ctrl;
    logic        start;
    logic        branch_inc;
    logic        load_inc;

    // State and launch-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            launched_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            launched_q <= launched_d;
        end
    end

    // Priority arbitration in RUN, MDU wait handling, launch-flag update.
    always_comb begin
        ctrl       = '0;
        start      = 1'b0;
        branch_inc = 1'b0;
        load_inc   = 1'b0;
        state_d    = state_q;
        launched_d = launched_q;

        if (reset) begin
            ctrl.flush_id  = 1'b1;
            ctrl.flush_exe = 1'b1;
            ctrl.flush_mem = 1'b1;
            ctrl.flush_wb  = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (dmem_stall) begin
                        ctrl.stall_if  = 1'b1;
                        ctrl.stall_id  = 1'b1;
                        ctrl.stall_exe = 1'b1;
                        ctrl.stall_mem = 1'b1;
                        ctrl.flush_wb  = 1'b1;
                    end else if (branch_hazard) begin
                        ctrl.flush_id  = 1'b1;
                        ctrl.flush_exe = 1'b1;
                        ctrl.flush_mem = 1'b1;
                        branch_inc     = 1'b1;
                    end else if (mdu_op_exe && !launched_q) begin
                        start          = 1'b1;
                        ctrl.stall_if  = 1'b1;
                        ctrl.stall_id  = 1'b1;
                        ctrl.stall_exe = 1'b1;
                        ctrl.flush_mem = 1'b1;
                        state_d        = MDU_WAIT;
                    end else if (load_hazard) begin
                        ctrl.stall_if  = 1'b1;
                        ctrl.stall_id  = 1'b1;
                        ctrl.flush_exe = 1'b1;
                        load_inc       = 1'b1;
                    end else if (imem_stall) begin
                        ctrl.stall_if  = 1'b1;
                        ctrl.flush_id  = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    // Completion cycle releases everything so EXE/MEM captures the result.
                    if (mdu_done) begin
                        state_d = RUN;
                    end else begin
                        ctrl.stall_if  = 1'b1;
                        ctrl.stall_id  = 1'b1;
                        ctrl.stall_exe = 1'b1;
                        ctrl.flush_mem = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase

            // Setting wins: the launch cycle always holds ID/EXE.
            if (start) begin
                launched_d = 1'b1;
            end else if (!ctrl.stall_exe || ctrl.flush_exe) begin
                launched_d = 1'b0;
            end
        end
    end

    assign stall_if  = ctrl.stall_if;
    assign stall_id  = ctrl.stall_id;
    assign stall_exe = ctrl.stall_exe;
    assign stall_mem = ctrl.stall_mem;
    assign flush_id  = ctrl.flush_id;
    assign flush_exe = ctrl.flush_exe;
    assign flush_mem = ctrl.flush_mem;
    assign flush_wb  = ctrl.flush_wb;
    assign mdu_start = start;
    assign mdu_busy  = (state_q == MDU_WAIT) && !reset;

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl.stall_if),
        .count (perf_stall_cycles)
    );

    perf_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_inc),
        .count (perf_branch_flushes)
    );

    perf_counter #(.CNT_W(CNT_W)) u_load_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (load_inc),
        .count (perf_load_bubbles)
    );

endmodule
